simd_stage_buffer: RTL



---
 rtl/simd_stage_buffer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/simd_stage_buffer.sv
// Decode-to-execute pipeline stage for the multi-lane datapath: per-lane operands,
// immediate and control word behind a valid/ready handshake with a one-entry skid register.
module simd_stage_buffer #(
  parameter int DATA_W = 16,
  parameter int LANES  = 3,
  parameter int CTRL_W = 11,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] reg1_in,
  input  logic [LANES*DATA_W-1:0] reg2_in,
  input  logic [LANES*DATA_W-1:0] ext_in,
  input  logic [CTRL_W-1:0]       ctrl_in,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] reg1_out,
  output logic [LANES*DATA_W-1:0] reg2_out,
  output logic [LANES*DATA_W-1:0] ext_out,
  output logic [CTRL_W-1:0]       ctrl_out,
  output logic [CNT_W-1:0]        stall_cnt
);

  logic              m_valid_reg, m_valid_next;
  logic              s_valid_reg, s_valid_next;
  logic [CTRL_W-1:0] m_ctrl_reg, s_ctrl_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;

  logic accept, pop;
  logic load_m_from_in, load_m_from_s, load_s;

  assign accept = in_valid & in_ready;
  assign pop    = m_valid_reg & out_ready;

  always_comb begin
    m_valid_next   = m_valid_reg;
    s_valid_next   = s_valid_reg;
    load_m_from_in = 1'b0;
    load_m_from_s  = 1'b0;
    load_s         = 1'b0;
    if (flush) begin
      m_valid_next = 1'b0;
      s_valid_next = 1'b0;
    end else if (!m_valid_reg) begin
      if (accept) begin
        load_m_from_in = 1'b1;
        m_valid_next   = 1'b1;
      end
    end else if (pop) begin
      // A full skid blocks accept, so refilling M from S never races the input.
      if (s_valid_reg) begin
        load_m_from_s = 1'b1;
        s_valid_next  = 1'b0;
      end else if (accept) begin
        load_m_from_in = 1'b1;
      end else begin
        m_valid_next = 1'b0;
      end
    end else if (accept) begin
      load_s       = 1'b1;
      s_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_reg <= 1'b0;
      s_valid_reg <= 1'b0;
      m_ctrl_reg  <= '0;
      s_ctrl_reg  <= '0;
    end else begin
      m_valid_reg <= m_valid_next;
      s_valid_reg <= s_valid_next;
      if (load_m_from_in)     m_ctrl_reg <= ctrl_in;
      else if (load_m_from_s) m_ctrl_reg <= s_ctrl_reg;
      if (load_s)             s_ctrl_reg <= ctrl_in;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [DATA_W-1:0] m_reg1_reg, m_reg2_reg, m_ext_reg;
      logic [DATA_W-1:0] s_reg1_reg, s_reg2_reg, s_ext_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          m_reg1_reg <= '0;
          m_reg2_reg <= '0;
          m_ext_reg  <= '0;
          s_reg1_reg <= '0;
          s_reg2_reg <= '0;
          s_ext_reg  <= '0;
        end else begin
          if (load_m_from_in) begin
            m_reg1_reg <= reg1_in[gi*DATA_W +: DATA_W];
            m_reg2_reg <= reg2_in[gi*DATA_W +: DATA_W];
            m_ext_reg  <= ext_in[gi*DATA_W +: DATA_W];
          end else if (load_m_from_s) begin
            m_reg1_reg <= s_reg1_reg;
            m_reg2_reg <= s_reg2_reg;
            m_ext_reg  <= s_ext_reg;
          end
          if (load_s) begin
            s_reg1_reg <= reg1_in[gi*DATA_W +: DATA_W];
            s_reg2_reg <= reg2_in[gi*DATA_W +: DATA_W];
            s_ext_reg  <= ext_in[gi*DATA_W +: DATA_W];
          end
        end
      end

      assign reg1_out[gi*DATA_W +: DATA_W] = m_reg1_reg;
      assign reg2_out[gi*DATA_W +: DATA_W] = m_reg2_reg;
      assign ext_out[gi*DATA_W +: DATA_W]  = m_ext_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (m_valid_reg && !out_ready && stall_cnt_reg != {CNT_W{1'b1}}) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  // in_ready comes straight from a register so out_ready never reaches it combinationally.
  assign in_ready  = !s_valid_reg;
  assign out_valid = m_valid_reg;
  assign ctrl_out  = m_valid_reg ? m_ctrl_reg : '0;
  assign stall_cnt = stall_cnt_reg;

endmodule
